// File: rtl/dmem_pkg.sv
// Shared types and default geometry for the data-memory port controller.
// The forwarding pipeline type is only used when DMEM_COLLISION_FWD_EN is defined.
package dmem_pkg;

    localparam int DMEM_DATA_W    = 16;
    localparam int DMEM_ADDR_W    = 9;
    localparam int DMEM_RSP_DEPTH = 4;
    localparam int DMEM_PTR_W     = $clog2(DMEM_RSP_DEPTH);

    // Read/write pointer of the default-depth response FIFO.
    typedef logic [DMEM_PTR_W-1:0] rsp_ptr_t;

    // One load travelling through S1/S2. fwd_data replaces the RAM output
    // when a same-cycle store to the same address was accepted with it.
    typedef struct packed {
        logic                   valid;
        logic                   fwd;
        logic [DMEM_DATA_W-1:0] fwd_data;
    } ld_pipe_t;

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Load-response FIFO: circular buffer with occupancy count output.
// The head entry is presented combinationally; data_o reads 0 while empty.
// The caller guarantees no push when full (credit-based flow control upstream).
module dmem_rsp_fifo
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_RSP_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_ready_i,
    output logic                       valid_o,
    output logic [DATA_W-1:0]          data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              pop;

    assign valid_o = (count_q != '0);
    assign pop     = valid_o && pop_ready_i;
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    // Pointer advance wraps naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Client-side controller for the simple dual-port data RAM (1-cycle read,
// old data on read-during-write). Loads: S1 issue -> S2 RAM -> response FIFO.
// Optional macro DMEM_COLLISION_FWD_EN forwards store data to a same-cycle,
// same-address load so that the pair behaves as store-then-load.
// DATA_W must equal dmem_pkg::DMEM_DATA_W (forwarding payload width).
module dmem_port_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int RSP_DEPTH = DMEM_RSP_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_read_address,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic              ld_fire, st_fire;
    logic              s1_ld, s2_ld;
    logic [DATA_W-1:0] push_data;
    logic [CNT_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  occupancy;

    logic [ADDR_W-1:0] ram_read_address_q, ram_read_address_d;
    logic [ADDR_W-1:0] ram_write_address_q, ram_write_address_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_write_q, ram_write_d;

    // Credit check from registered state only: every load in S1/S2 already
    // owns a FIFO slot, so rsp_ready never reaches ld_ready combinationally.
    assign occupancy = {1'b0, fifo_count} + OCC_W'(s1_ld) + OCC_W'(s2_ld);
    assign ld_ready  = !reset && (occupancy < OCC_W'(RSP_DEPTH));
    assign st_ready  = !reset;
    assign ld_fire   = ld_valid && ld_ready;
    assign st_fire   = st_valid && st_ready;

    // A store sitting in S1 during a reset cycle must not reach the RAM.
    assign ram_write         = ram_write_q && !reset;
    assign ram_read_address  = ram_read_address_q;
    assign ram_write_address = ram_write_address_q;
    assign ram_din           = ram_din_q;

    // S1 next state: RAM ports hold their last value when nothing is issued.
    always_comb begin
        ram_read_address_d  = ram_read_address_q;
        ram_write_address_d = ram_write_address_q;
        ram_din_d           = ram_din_q;
        ram_write_d         = st_fire;
        if (ld_fire) ram_read_address_d = ld_addr;
        if (st_fire) begin
            ram_write_address_d = st_addr;
            ram_din_d           = st_wdata;
        end
    end

    // S1 RAM-port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_read_address_q  <= '0;
            ram_write_address_q <= '0;
            ram_din_q           <= '0;
            ram_write_q         <= 1'b0;
        end else begin
            ram_read_address_q  <= ram_read_address_d;
            ram_write_address_q <= ram_write_address_d;
            ram_din_q           <= ram_din_d;
            ram_write_q         <= ram_write_d;
        end
    end

`ifdef DMEM_COLLISION_FWD_EN
    ld_pipe_t s1_q, s1_d, s2_q;

    // Capture a same-cycle, same-address store alongside the load.
    always_comb begin
        s1_d          = '0;
        s1_d.valid    = ld_fire;
        s1_d.fwd      = ld_fire && st_fire && (ld_addr == st_addr);
        s1_d.fwd_data = st_wdata;
    end

    // Load pipeline S1 -> S2, carrying the forwarding payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s1_q;
        end
    end

    assign s1_ld     = s1_q.valid;
    assign s2_ld     = s2_q.valid;
    assign push_data = s2_q.fwd ? s2_q.fwd_data : ram_dout;
`else
    logic s1_ld_q, s2_ld_q;

    // Load pipeline S1 -> S2 (valid bits only, no collision state).
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_ld_q <= 1'b0;
            s2_ld_q <= 1'b0;
        end else begin
            s1_ld_q <= ld_fire;
            s2_ld_q <= s1_ld_q;
        end
    end

    assign s1_ld     = s1_ld_q;
    assign s2_ld     = s2_ld_q;
    assign push_data = ram_dout;
`endif

    dmem_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (s2_ld),
        .push_data_i (push_data),
        .pop_ready_i (rsp_ready),
        .valid_o     (rsp_valid),
        .data_o      (rsp_rdata),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Self-checking bench for dmem_port_ctrl with a behavioural RAM model
// (1-cycle read, old data on read-during-write) behind the RAM ports.
module tb_dmem_port_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid = 1'b0, st_valid = 1'b0, rsp_ready = 1'b1;
    logic [8:0]  ld_addr = '0, st_addr = '0;
    logic [15:0] st_wdata = '0;
    logic        ld_ready, st_ready, rsp_valid, ram_write;
    logic [15:0] rsp_rdata, ram_din, ram_dout;
    logic [8:0]  ram_read_address, ram_write_address;

    always #5 clk = ~clk;

    dmem_port_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .ld_valid          (ld_valid),
        .ld_ready          (ld_ready),
        .ld_addr           (ld_addr),
        .st_valid          (st_valid),
        .st_ready          (st_ready),
        .st_addr           (st_addr),
        .st_wdata          (st_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .ram_read_address  (ram_read_address),
        .ram_write_address (ram_write_address),
        .ram_write         (ram_write),
        .ram_din           (ram_din),
        .ram_dout          (ram_dout)
    );

    function automatic logic [15:0] preload(logic [8:0] a);
        if (a <= 9'h013) return 16'h5000 + 16'(a);
        if (a == 9'h020) return 16'h1111;
        if (a >= 9'h100 && a < 9'h110) return 16'h7000 + 16'(a - 9'h100);
        return 16'h0000;
    endfunction

    // RAM model: preloaded on the first edge (reset is high, so no write is lost).
    logic [15:0] ram_mem [512];
    bit          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int a = 0; a < 512; a++) ram_mem[a] <= preload(9'(a));
            ram_loaded <= 1'b1;
        end else if (ram_write) begin
            ram_mem[ram_write_address] <= ram_din;
        end
        ram_dout <= ram_mem[ram_read_address];
    end

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        st_v;
        logic [8:0]  st_a;
        logic [15:0] st_d;
        logic        ld_v;
        logic [8:0]  ld_a;
        logic [15:0] exp_d;
    } vec_t;
    vec_t vecs[8];

    int          cyc = 0, n_checks = 0, n_pass = 0, rsp_cnt = 0;
    logic [15:0] ld_exp = '0;
    bit          chk_lat = 1'b1, last_ld_acc = 1'b0, last_st_acc = 1'b0, prev_st = 1'b0;
    logic [8:0]  prev_st_addr = '0;
    logic [15:0] prev_st_data = '0;

`ifdef DMEM_COLLISION_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: sample at negedge (RAM write, responses, acceptances), return at posedge+1.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        check("ram_write", ram_write, prev_st && !reset);
        if (prev_st && !reset) begin
            check("ram_write_address", ram_write_address, prev_st_addr);
            check("ram_din", ram_din, prev_st_data);
        end
        if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            $display("rsp cycle %0d data=0x%04h", cyc, rsp_rdata);
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", rsp_rdata, e.data);
                if (chk_lat) check("rsp_latency", 64'(cyc - e.cyc), 3);
            end
        end
        last_ld_acc = ld_valid && ld_ready;
        last_st_acc = st_valid && st_ready;
        if (last_ld_acc) begin
            e.data = ld_exp;
            e.cyc  = cyc;
            exp_q.push_back(e);
        end
        prev_st      = last_st_acc;
        prev_st_addr = st_addr;
        prev_st_data = st_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        check("drain_empty", exp_q.size(), 0);
        repeat (3) step();
    endtask

    initial begin
        int idx;
        int base;

        // Reset and idle outputs
        reset = 1'b1;
        step();
        step();
        check("rst_ld_ready", ld_ready, 0);
        check("rst_st_ready", st_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_outputs",
                  {rsp_valid, rsp_rdata, ram_read_address, ram_write_address, ram_din, ram_write, ld_ready, st_ready},
                  {1'b0, 16'h0, 9'h0, 9'h0, 16'h0, 1'b0, 1'b1, 1'b1});
        end

        // 20 back-to-back loads, one response per cycle
        for (int i = 0; i < 20; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 9'(i);
            ld_exp   = preload(9'(i));
            step();
            check("burst_ld_ready", last_ld_acc, 1);
        end
        ld_valid = 1'b0;
        drain();

        // Backpressure: exactly RSP_DEPTH loads accepted, then drain in order
        rsp_ready = 1'b0;
        chk_lat   = 1'b0;
        idx       = 0;
        for (int k = 0; k < 10; k++) begin
            ld_valid = 1'b1;
            ld_addr  = 9'h100 + 9'(idx);
            ld_exp   = preload(ld_addr);
            step();
            if (last_ld_acc) idx++;
        end
        check("bp_accepted", idx, 4);
        check("bp_ld_ready", ld_ready, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_head", rsp_rdata, 16'h7000);
        ld_valid  = 1'b0;
        rsp_ready = 1'b1;
        base      = rsp_cnt;
        drain();
        check("bp_rsp_count", rsp_cnt - base, 4);
        chk_lat = 1'b1;

        // Store/load ordering vectors
        vecs[0] = '{1'b1, 9'h010, 16'hBEEF, 1'b0, 9'h000, 16'h0000};
        vecs[1] = '{1'b0, 9'h000, 16'h0000, 1'b1, 9'h010, 16'hBEEF};
        vecs[2] = '{1'b1, 9'h020, 16'h2222, 1'b1, 9'h020, FWD ? 16'h2222 : 16'h1111};
        vecs[3] = '{1'b0, 9'h000, 16'h0000, 1'b1, 9'h020, 16'h2222};
        vecs[4] = '{1'b1, 9'h030, 16'h0A0A, 1'b1, 9'h031, 16'h0000};
        vecs[5] = '{1'b0, 9'h000, 16'h0000, 1'b1, 9'h030, 16'h0A0A};
        vecs[6] = '{1'b1, 9'h031, 16'h5A5A, 1'b1, 9'h031, FWD ? 16'h5A5A : 16'h0000};
        vecs[7] = '{1'b0, 9'h000, 16'h0000, 1'b1, 9'h031, 16'h5A5A};
        for (int r = 0; r < 8; r++) begin
            st_valid = vecs[r].st_v;
            st_addr  = vecs[r].st_a;
            st_wdata = vecs[r].st_d;
            ld_valid = vecs[r].ld_v;
            ld_addr  = vecs[r].ld_a;
            ld_exp   = vecs[r].exp_d;
            step();
            if (vecs[r].ld_v) check("vec_ld_accept", last_ld_acc, 1);
            if (vecs[r].st_v) check("vec_st_accept", last_st_acc, 1);
        end
        st_valid = 1'b0;
        ld_valid = 1'b0;
        drain();

        // Reset with two loads in flight and a store in S1
        ld_valid = 1'b1;
        ld_addr  = 9'h005;
        ld_exp   = preload(9'h005);
        step();
        ld_addr  = 9'h006;
        ld_exp   = preload(9'h006);
        st_valid = 1'b1;
        st_addr  = 9'h040;
        st_wdata = 16'h4444;
        step();
        ld_valid = 1'b0;
        st_valid = 1'b0;
        reset    = 1'b1;
        step();
        check("midrst_ld_ready", ld_ready, 0);
        check("midrst_st_ready", st_ready, 0);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_rsp_valid", rsp_valid, 0);
        end
        check("midrst_ram_unwritten", ram_mem[9'h040], 16'h0000);
        check("midrst_rsp_rdata", rsp_rdata, 16'h0000);
        ld_valid = 1'b1;
        ld_addr  = 9'h040;
        ld_exp   = 16'h0000;
        step();
        ld_addr  = 9'h005;
        ld_exp   = preload(9'h005);
        step();
        ld_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
